// File: rtl/pe_operand_collector_if.sv
// Operand collector bus: the A/B operand streams coming from the PE input
// muxes and the operand pair going to the functional unit.
//
// Handshake: every stream is valid/ready. A transfer happens on the rising
// clock edge where both valid and ready are high. A producer holds its
// payload stable while valid is high and ready is low. Ready may depend on
// internal state only, never on the partner's valid in the same cycle.
interface pe_operand_collector_if #(
  parameter int N_BITS = 32
);
  logic [N_BITS-1:0] a_data_i;
  logic              a_valid_i;
  logic              a_ready_o;
  logic [N_BITS-1:0] b_data_i;
  logic              b_valid_i;
  logic              b_ready_o;
  logic              flush_i;
  logic              acc_loopback_i;
  logic              fu_ready_i;
  logic [N_BITS-1:0] fu_res_i;
  logic [N_BITS-1:0] a_o;
  logic [N_BITS-1:0] b_o;
  logic              ops_valid_o;

  // Collector side
  modport slave (
    input  a_data_i, a_valid_i, b_data_i, b_valid_i,
    input  flush_i, acc_loopback_i, fu_ready_i, fu_res_i,
    output a_ready_o, b_ready_o, a_o, b_o, ops_valid_o
  );

  // Upstream mux / FU side
  modport master (
    output a_data_i, a_valid_i, b_data_i, b_valid_i,
    output flush_i, acc_loopback_i, fu_ready_i, fu_res_i,
    input  a_ready_o, b_ready_o, a_o, b_o, ops_valid_o
  );
endinterface

// File: rtl/pe_operand_collector.sv
// Operand collector in front of the PE functional unit.
// Two independent 2-entry FIFOs buffer operand A and operand B; their heads
// are paired and offered to the FU. While the FU asserts accumulation
// loopback, operand B is taken from the feedback register holding the last
// FU result instead of the B FIFO.
//
// Optional feature macro: PE_OPCOLL_CONST_B_EN
//   When defined, const_b_i/const_b_sel_i exist and a constant B can replace
//   the B FIFO (loopback still has higher priority).
module pe_operand_collector #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  pe_operand_collector_if.slave     bus
`ifdef PE_OPCOLL_CONST_B_EN
  ,
  input  logic [N_BITS-1:0]         const_b_i,
  input  logic                      const_b_sel_i
`endif
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  // A FIFO state
  logic [N_BITS-1:0] a_mem [2];
  logic              a_wr_ptr;
  logic              a_rd_ptr;
  logic [1:0]        a_cnt;

  // B FIFO state
  logic [N_BITS-1:0] b_mem [2];
  logic              b_wr_ptr;
  logic              b_rd_ptr;
  logic [1:0]        b_cnt;

  // Last FU result, used as B during accumulation
  logic [N_BITS-1:0] fb_reg;

  logic [N_BITS-1:0] a_head;
  logic [N_BITS-1:0] b_head;
  logic [N_BITS-1:0] b_sel;
  logic              b_needed;
  logic              a_ready;
  logic              b_ready;
  logic              ops_valid;
  logic              push_a;
  logic              push_b;
  logic              fire;
  logic              pop_a;
  logic              pop_b;

  // Ready/valid and FIFO heads; an empty head reads as zero
  always_comb begin
    a_ready   = (a_cnt < FULL_CNT);
    b_ready   = (b_cnt < FULL_CNT);
    a_head    = (a_cnt != 2'd0) ? a_mem[a_rd_ptr] : '0;
    b_head    = (b_cnt != 2'd0) ? b_mem[b_rd_ptr] : '0;
    push_a    = bus.a_valid_i & a_ready;
    push_b    = bus.b_valid_i & b_ready;
  end

  // B source priority: loopback, then constant (if built in), then FIFO
  always_comb begin
    b_sel    = b_head;
    b_needed = 1'b1;
    if (bus.acc_loopback_i) begin
      b_sel    = fb_reg;
      b_needed = 1'b0;
    end
`ifdef PE_OPCOLL_CONST_B_EN
    else if (const_b_sel_i) begin
      b_sel    = const_b_i;
      b_needed = 1'b0;
    end
`endif
  end

  // Pair validity and pops; B is only consumed when it came from its FIFO
  always_comb begin
    ops_valid = (a_cnt != 2'd0) & (~b_needed | (b_cnt != 2'd0));
    fire      = ops_valid & bus.fu_ready_i;
    pop_a     = fire;
    pop_b     = fire & b_needed;
  end

  assign bus.a_ready_o   = a_ready;
  assign bus.b_ready_o   = b_ready;
  assign bus.a_o         = a_head;
  assign bus.b_o         = b_sel;
  assign bus.ops_valid_o = ops_valid;

  // A FIFO: flush drops counts/pointers and any same-cycle push; storage is
  // left as is because the zero-head gating hides stale entries
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) a_mem[i] <= '0;
      a_wr_ptr <= 1'b0;
      a_rd_ptr <= 1'b0;
      a_cnt    <= 2'd0;
    end else if (bus.flush_i) begin
      a_wr_ptr <= 1'b0;
      a_rd_ptr <= 1'b0;
      a_cnt    <= 2'd0;
    end else begin
      if (push_a) begin
        a_mem[a_wr_ptr] <= bus.a_data_i;
        a_wr_ptr        <= ~a_wr_ptr;
      end
      if (pop_a) begin
        a_rd_ptr <= ~a_rd_ptr;
      end
      unique case ({push_a, pop_a})
        2'b10:   a_cnt <= a_cnt + 2'd1;
        2'b01:   a_cnt <= a_cnt - 2'd1;
        default: a_cnt <= a_cnt;
      endcase
    end
  end

  // B FIFO: same structure as A, popped only when B came from the FIFO
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) b_mem[i] <= '0;
      b_wr_ptr <= 1'b0;
      b_rd_ptr <= 1'b0;
      b_cnt    <= 2'd0;
    end else if (bus.flush_i) begin
      b_wr_ptr <= 1'b0;
      b_rd_ptr <= 1'b0;
      b_cnt    <= 2'd0;
    end else begin
      if (push_b) begin
        b_mem[b_wr_ptr] <= bus.b_data_i;
        b_wr_ptr        <= ~b_wr_ptr;
      end
      if (pop_b) begin
        b_rd_ptr <= ~b_rd_ptr;
      end
      unique case ({push_b, pop_b})
        2'b10:   b_cnt <= b_cnt + 2'd1;
        2'b01:   b_cnt <= b_cnt - 2'd1;
        default: b_cnt <= b_cnt;
      endcase
    end
  end

  // Feedback register captures the FU result on every accepted pair
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fb_reg <= '0;
    end else if (bus.flush_i) begin
      fb_reg <= '0;
    end else if (fire) begin
      fb_reg <= bus.fu_res_i;
    end
  end

endmodule
